cdb_broadcast: RTL

- Complete-stage broadcaster. Collects finished results from the functional units and drives the common data bus (CDB).
- The CDB carries up to N tags per cycle, plus a count, back to the reservation station wakeup logic, map table and ROB.
- Each FU has a one-entry holding buffer with a ready handshake, so the FU stalls when it loses arbitration.
- Selection among pending results is round-robin, so no FU starves.

---
 rtl/cdb_broadcast.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cdb_broadcast.sv
// cdb_broadcast: complete-stage broadcaster.
// Collects finished results from NUM_FU functional units. Each unit has a
// one-entry holding buffer. Up to N results per cycle are driven onto the
// registered common data bus (CDB), chosen by round-robin.
//
// Ports:
//   clock, reset  - single clock, synchronous active-high reset
//   squash        - flush of all pending results (held and incoming)
//   fu_valid/tag/data - per-FU completed result
//   fu_ready      - per-FU accept strobe (buffer empty or being drained)
//   cdb_valid/tags/data - registered CDB slots, packed from slot 0
//   num_in_cdb    - number of valid CDB slots
module cdb_broadcast #(
  parameter int N             = 3,
  parameter int NUM_FU        = 6,
  parameter int PHYS_REG_BITS = 6,
  parameter int XLEN          = 32
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   squash,
  input  logic [NUM_FU-1:0]                      fu_valid,
  input  logic [NUM_FU-1:0][PHYS_REG_BITS-1:0]   fu_tag,
  input  logic [NUM_FU-1:0][XLEN-1:0]            fu_data,
  output logic [NUM_FU-1:0]                      fu_ready,
  output logic [N-1:0]                           cdb_valid,
  output logic [N-1:0][PHYS_REG_BITS-1:0]        cdb_tags,
  output logic [N-1:0][XLEN-1:0]                 cdb_data,
  output logic [$clog2(N+1)-1:0]                 num_in_cdb
);

  localparam int IDXW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int CNTW = $clog2(N+1);

  logic [NUM_FU-1:0]                    hold_occ_q, hold_occ_d;
  logic [NUM_FU-1:0][PHYS_REG_BITS-1:0] hold_tag_q, hold_tag_d;
  logic [NUM_FU-1:0][XLEN-1:0]          hold_data_q, hold_data_d;
  logic [IDXW-1:0]                      rr_ptr_q, rr_ptr_d;
  logic [N-1:0]                         cdb_valid_q, cdb_valid_d;
  logic [N-1:0][PHYS_REG_BITS-1:0]      cdb_tags_q, cdb_tags_d;
  logic [N-1:0][XLEN-1:0]               cdb_data_q, cdb_data_d;
  logic [CNTW-1:0]                      num_q, num_d;

  logic [NUM_FU-1:0]                    grant_s;
  logic [NUM_FU-1:0]                    fu_ready_s;
  logic [N-1:0]                         slot_valid_s;
  logic [N-1:0][PHYS_REG_BITS-1:0]      slot_tag_s;
  logic [N-1:0][XLEN-1:0]               slot_data_s;
  logic [CNTW-1:0]                      cnt_s;
  logic [IDXW-1:0]                      last_s;

  // Round-robin arbitration: scan from rr_ptr, grant up to N occupied buffers
  // and pack them into slots in scan order.
  always_comb begin : arb_comb
    int idx_v;
    idx_v        = 0;
    grant_s      = '0;
    slot_valid_s = '0;
    slot_tag_s   = '0;
    slot_data_s  = '0;
    cnt_s        = '0;
    last_s       = '0;
    for (int o = 0; o < NUM_FU; o++) begin
      idx_v = int'(rr_ptr_q) + o;
      if (idx_v >= NUM_FU) begin
        idx_v = idx_v - NUM_FU;
      end else begin
        idx_v = idx_v;
      end
      for (int i = 0; i < NUM_FU; i++) begin
        if ((i == idx_v) && hold_occ_q[i] && (cnt_s < CNTW'(N))) begin
          grant_s[i] = 1'b1;
          for (int j = 0; j < N; j++) begin
            if (j == int'(cnt_s)) begin
              slot_valid_s[j] = 1'b1;
              slot_tag_s[j]   = hold_tag_q[i];
              slot_data_s[j]  = hold_data_q[i];
            end else begin
              slot_valid_s[j] = slot_valid_s[j];
            end
          end
          last_s = IDXW'(i);
          cnt_s  = cnt_s + CNTW'(1);
        end else begin
          grant_s[i] = grant_s[i];
        end
      end
    end
  end

  // A buffer can take a new result when empty or when it is drained this cycle,
  // which is what lets one FU sustain a result per cycle.
  assign fu_ready_s = ~hold_occ_q | grant_s;
  assign fu_ready   = fu_ready_s;

  // Next-state: buffer load/drain, CDB slot capture, round-robin pointer.
  always_comb begin
    hold_occ_d  = hold_occ_q;
    hold_tag_d  = hold_tag_q;
    hold_data_d = hold_data_q;
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = slot_valid_s;
    cdb_tags_d  = slot_tag_s;
    cdb_data_d  = slot_data_s;
    num_d       = cnt_s;
    if (squash) begin
      // Tags/data of the bus are left as-is; only valid and count are killed.
      hold_occ_d  = '0;
      cdb_valid_d = '0;
      cdb_tags_d  = cdb_tags_q;
      cdb_data_d  = cdb_data_q;
      num_d       = '0;
      rr_ptr_d    = '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_valid[i] && fu_ready_s[i]) begin
          hold_occ_d[i]  = 1'b1;
          hold_tag_d[i]  = fu_tag[i];
          hold_data_d[i] = fu_data[i];
        end else if (grant_s[i]) begin
          hold_occ_d[i] = 1'b0;
        end else begin
          hold_occ_d[i] = hold_occ_q[i];
        end
      end
      if (cnt_s != '0) begin
        if (last_s == IDXW'(NUM_FU-1)) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = last_s + IDXW'(1);
        end
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_occ_q  <= '0;
      hold_tag_q  <= '0;
      hold_data_q <= '0;
      rr_ptr_q    <= '0;
      cdb_valid_q <= '0;
      cdb_tags_q  <= '0;
      cdb_data_q  <= '0;
      num_q       <= '0;
    end else begin
      hold_occ_q  <= hold_occ_d;
      hold_tag_q  <= hold_tag_d;
      hold_data_q <= hold_data_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tags_q  <= cdb_tags_d;
      cdb_data_q  <= cdb_data_d;
      num_q       <= num_d;
    end
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_tags   = cdb_tags_q;
  assign cdb_data   = cdb_data_q;
  assign num_in_cdb = num_q;

endmodule
